// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// sram_responder : device-side async-SRAM pin responder with byte-lane writes,
// latency-timed reads and a CRE config write. Optional macro: SRAM_RESET_CLEAR_EN.
// Revision: 1.0
// ============================================================================
module sram_responder #(
   parameter int            AW       = 4,
   parameter int            DW       = 8,
   parameter int            READ_LAT = 2,
   parameter logic [AW-1:0] CFG_RST  = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] sram_addr,
   inout  wire  [DW-1:0] sram_data,
   input  logic          ce_n,
   input  logic          we_n,
   input  logic          oe_n,
   input  logic          adv_n,
   input  logic          cre,
   input  logic          lb_n,
   input  logic          ub_n,
   output logic          busy,
   output logic [AW-1:0] cfg_reg,
   output logic [15:0]   wr_count,
   output logic [15:0]   rd_count,
   output logic [2:0]    state
);
   localparam int         HW          = DW / 2;
   localparam int         DEPTH       = 1 << AW;
   localparam logic [3:0] WAIT_RELOAD = 4'(READ_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_ACC   = 3'd1,
      S_CFG_WR   = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_RD_DRIVE = 3'd4,
      S_CLEAR    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          ce_q, we_q, oe_q, cre_q, lb_q, ub_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] din_q;
   logic [AW-1:0] lat_addr_q, lat_addr_d;
   logic [3:0]    wait_q, wait_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          hold_lb_q, hold_lb_d, hold_ub_q, hold_ub_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [AW-1:0] cfg_q, cfg_d;
   logic [15:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic          w_mem_we, w_mem_lo, w_mem_hi;
   logic [AW-1:0] w_mem_addr;
   logic [DW-1:0] w_mem_wdata;
   logic          w_abort, w_drive, w_unused;
`ifdef SRAM_RESET_CLEAR_EN
   logic          clr_pend_q, clr_pend_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
`endif

   assign w_unused = adv_n;
   assign w_abort  = ce_q | oe_q | ~we_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q   <= 1'b1;
         we_q   <= 1'b1;
         oe_q   <= 1'b1;
         cre_q  <= 1'b0;
         lb_q   <= 1'b1;
         ub_q   <= 1'b1;
         addr_q <= '0;
         din_q  <= '0;
      end else begin
         ce_q   <= ce_n;
         we_q   <= we_n;
         oe_q   <= oe_n;
         cre_q  <= cre;
         lb_q   <= lb_n;
         ub_q   <= ub_n;
         addr_q <= sram_addr;
         din_q  <= sram_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lat_addr_q <= '0;
         wait_q     <= '0;
         hold_q     <= '0;
         hold_lb_q  <= 1'b1;
         hold_ub_q  <= 1'b1;
         rdata_q    <= '0;
         cfg_q      <= CFG_RST;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
`ifdef SRAM_RESET_CLEAR_EN
         clr_pend_q <= 1'b1;
         clr_addr_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lat_addr_q <= lat_addr_d;
         wait_q     <= wait_d;
         hold_q     <= hold_d;
         hold_lb_q  <= hold_lb_d;
         hold_ub_q  <= hold_ub_d;
         rdata_q    <= rdata_d;
         cfg_q      <= cfg_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
`ifdef SRAM_RESET_CLEAR_EN
         clr_pend_q <= clr_pend_d;
         clr_addr_q <= clr_addr_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      lat_addr_d  = lat_addr_q;
      wait_d      = wait_q;
      hold_d      = hold_q;
      hold_lb_d   = hold_lb_q;
      hold_ub_d   = hold_ub_q;
      rdata_d     = rdata_q;
      cfg_d       = cfg_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      w_mem_we    = 1'b0;
      w_mem_addr  = lat_addr_q;
      w_mem_wdata = hold_q;
      w_mem_lo    = ~hold_lb_q;
      w_mem_hi    = ~hold_ub_q;
`ifdef SRAM_RESET_CLEAR_EN
      clr_pend_d  = clr_pend_q;
      clr_addr_d  = clr_addr_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef SRAM_RESET_CLEAR_EN
            if (clr_pend_q) begin
               clr_pend_d = 1'b0;
               clr_addr_d = '0;
               state_d    = S_CLEAR;
            end else
`endif
            // The entry cycle is itself a we-low beat, so capture it here.
            if (!ce_q && !we_q) begin
               lat_addr_d = addr_q;
               hold_d     = din_q;
               hold_lb_d  = lb_q;
               hold_ub_d  = ub_q;
               state_d    = cre_q ? S_CFG_WR : S_WR_ACC;
            end else if (!ce_q && !oe_q) begin
               lat_addr_d = addr_q;
               wait_d     = WAIT_RELOAD;
               state_d    = S_RD_WAIT;
            end
         end
         S_WR_ACC: begin
            if (!ce_q && !we_q) begin
               hold_d    = din_q;
               hold_lb_d = lb_q;
               hold_ub_d = ub_q;
            end else begin
               w_mem_we = 1'b1;
               wr_cnt_d = wr_cnt_q + 16'd1;
               state_d  = S_IDLE;
            end
         end
         S_CFG_WR: begin
            if (!ce_q && !we_q) begin
               lat_addr_d = addr_q;
            end else begin
               cfg_d   = lat_addr_q;
               state_d = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            if (w_abort) begin
               state_d = S_IDLE;
            end else if (wait_q == 4'd0) begin
               rdata_d  = mem_q[lat_addr_q];
               rd_cnt_d = rd_cnt_q + 16'd1;
               state_d  = S_RD_DRIVE;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_RD_DRIVE: begin
            if (w_abort) begin
               state_d = S_IDLE;
            end else if (addr_q != lat_addr_q) begin
               lat_addr_d = addr_q;
               wait_d     = WAIT_RELOAD;
               state_d    = S_RD_WAIT;
            end
         end
`ifdef SRAM_RESET_CLEAR_EN
         S_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = clr_addr_q;
            w_mem_wdata = '0;
            w_mem_lo    = 1'b1;
            w_mem_hi    = 1'b1;
            clr_addr_d  = clr_addr_q + AW'(1);
            if (clr_addr_q == {AW{1'b1}}) begin
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Gating on rst drops a commit that lands in the reset cycle.
   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) begin
         if (w_mem_lo) mem_q[w_mem_addr][HW-1:0]  <= w_mem_wdata[HW-1:0];
         if (w_mem_hi) mem_q[w_mem_addr][DW-1:HW] <= w_mem_wdata[DW-1:HW];
      end
   end

   // Drive follows the raw pins so the bus releases the instant the host lets go.
   assign w_drive = !rst && (state_q == S_RD_DRIVE) && !ce_n && !oe_n && we_n;
   assign sram_data[HW-1:0]  = (w_drive && !lb_n) ? rdata_q[HW-1:0]  : {HW{1'bz}};
   assign sram_data[DW-1:HW] = (w_drive && !ub_n) ? rdata_q[DW-1:HW] : {(DW-HW){1'bz}};

`ifdef SRAM_RESET_CLEAR_EN
   assign busy = (state_q == S_CLEAR);
`else
   assign busy = 1'b0;
`endif
   assign cfg_reg  = cfg_q;
   assign wr_count = wr_cnt_q;
   assign rd_count = rd_cnt_q;
   assign state    = state_q;

endmodule
`default_nettype wire
